dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder (slave) end of the data-memory access path driven by the CPU MEM stage.
- Accepts one load/store request at a time over a valid/ready handshake and models a multi-cycle memory with configurable wait states.
- Performs byte/half/word accesses on a word-organised internal array.
- Returns read data (sign/zero extended) plus an error flag over a second valid/ready handshake.

Parameters:
- ADDR_W, 6, word-index bits; array depth 2^ADDR_W 32-bit words (byte address bits [ADDR_W+1:2]).
- LATENCY, 2, wait cycles between request accept and response valid; legal 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  access faulted.

Behaviour:
- One clock, synchronous active-low reset. Reset clears control state only; array contents are not reset.
- Reset values: req_ready=0 during reset and 1 on the first cycle after; rsp_valid=0, rsp_rdata=0, rsp_err=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we/size/unsigned/addr/wdata and load the counter with LATENCY.
  - Go to WAIT if LATENCY>0, else to RESP.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - At count==1, the next state is RESP.
- Entering RESP (single commit point):
  - Compute error first.
  - A store with no error writes only the selected byte lanes.
  - A load reads the word, selects the lane, and extends it; rsp_rdata/rsp_err are registered here.
- Response timing: rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid and rsp_rdata next cycle.
  - No new request is accepted in the same cycle as the response handshake; minimum initiation interval is LATENCY+2 cycles.
- Lane select:
  - byte → addr[1:0] chooses byte lane.
  - half → addr[1] chooses half lane.
  - word → whole word.
- Errors (rsp_err=1, no write, rsp_rdata=0):
  - req_size==11.
  - Any req_addr bit above ADDR_W+1 set (out of range, no wrap).
  - Misalignment per Optional Feature.
- Abort: reset asserted in WAIT aborts the access with no write and no response. A store already committed in RESP remains written.
- Read-after-write: a load following a store to the same word returns the new data.
- Inputs are ignored outside the IDLE handshake.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=00, sets rsp_err=1 with no write.
- Undefined: low address bits that would misalign are ignored. Half uses addr[1] only; word forces addr[1:0]=00. No alignment error is raised.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles → rsp_valid=0, req_ready=0; release → req_ready=1 next cycle.
- Word store/load, LATENCY=2: store 0xDEADBEEF @0x10, then load word @0x10 → rsp_valid 3 cycles after each accept; load returns 0xDEADBEEF, rsp_err=0.
- Byte/half lanes:
  - Store byte 0x80 @0x13 over word 0x00000000, then signed byte load @0x13 → 0xFFFFFF80.
  - Unsigned byte load @0x13 → 0x00000080.
  - Word load @0x10 → 0x80000000.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_rdata stable, req_ready=0 throughout; handshake on cycle 6 → IDLE.
- Errors:
  - Address 0x100 with ADDR_W=6 → rsp_err=1, memory unchanged.
  - Word store @0x12 → with DMEM_ALIGN_CHECK_EN rsp_err=1 and no write; without it, word @0x10 is written.
- Reset mid-access: accept store 0x12345678 @0x20, assert reset in WAIT → no response; subsequent load @0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, LATENCY wait cycles, byte/half/word lanes.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module dmem_responder #(
   parameter int ADDR_W  = 6,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_unsigned;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic [31:0] mem [2**ADDR_W];

   logic        cur_we;
   logic [1:0]  cur_size;
   logic        cur_unsigned;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic        accept;
   logic        commit;
   logic [ADDR_W-1:0] widx;
   logic [1:0]  eff_off;
   logic        misaligned;
   logic        acc_err;
   logic [31:0] rword;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] resp_data;
   logic [3:0]  byte_en;
   logic [31:0] wlane;

   // With zero latency the commit happens on the accept edge, so the live request is used directly.
   assign cur_we       = (state == IDLE) ? req_we       : lat_we;
   assign cur_size     = (state == IDLE) ? req_size     : lat_size;
   assign cur_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
   assign cur_addr     = (state == IDLE) ? req_addr     : lat_addr;
   assign cur_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;

   assign accept = (state == IDLE) && req_valid && req_ready;
   assign commit = reset && ((accept && (LATENCY == 0)) || (state == WAIT && cnt == 4'd1));
   assign widx   = cur_addr[ADDR_W+1:2];
   assign rword  = mem[widx];

   always_comb begin
      eff_off    = cur_addr[1:0];
      misaligned = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      misaligned = (cur_size == 2'b01 && cur_addr[0]) ||
                   (cur_size == 2'b10 && cur_addr[1:0] != 2'b00);
`else
      if (cur_size == 2'b01)
         eff_off = {cur_addr[1], 1'b0};
      else if (cur_size == 2'b10)
         eff_off = 2'b00;
`endif
   end

   assign acc_err = (cur_size == 2'b11) || (|cur_addr[31:ADDR_W+2]) || misaligned;

   always_comb begin
      case (eff_off)
         2'd0:    ld_byte = rword[7:0];
         2'd1:    ld_byte = rword[15:8];
         2'd2:    ld_byte = rword[23:16];
         default: ld_byte = rword[31:24];
      endcase
      ld_half = eff_off[1] ? rword[31:16] : rword[15:0];
      case (cur_size)
         2'b00:   ld_data = cur_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = cur_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         2'b10:   ld_data = rword;
         default: ld_data = 32'd0;
      endcase
      case (cur_size)
         2'b00:   byte_en = 4'b0001 << eff_off;
         2'b01:   byte_en = 4'b0011 << eff_off;
         2'b10:   byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
      case (cur_size)
         2'b00:   wlane = {4{cur_wdata[7:0]}};
         2'b01:   wlane = {2{cur_wdata[15:0]}};
         default: wlane = cur_wdata;
      endcase
      resp_data = (cur_we || acc_err) ? 32'd0 : ld_data;
   end

   // Array is deliberately outside reset so an aborted access leaves contents untouched.
   always_ff @(posedge clk) begin
      if (commit && cur_we && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i])
               mem[widx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_we       <= req_we;
                  lat_size     <= req_size;
                  lat_unsigned <= req_unsigned;
                  lat_addr     <= req_addr;
                  lat_wdata    <= req_wdata;
                  cnt          <= 4'(LATENCY);
                  req_ready    <= 1'b0;
                  if (LATENCY == 0) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= resp_data;
                     rsp_err   <= acc_err;
                  end else begin
                     state <= WAIT;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= resp_data;
                  rsp_err   <= acc_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
